// File: rtl/expipe_pkg.sv
// Execution-pipeline types shared between reservation stations, units and the ROB.
package expipe_pkg;

  localparam int ROB_IDX_W = 4;

  typedef logic [ROB_IDX_W-1:0] rob_idx_t;

  typedef enum logic [2:0] {
    BEQ  = 3'd0,
    BNE  = 3'd1,
    BLT  = 3'd2,
    BGE  = 3'd3,
    BLTU = 3'd4,
    BGEU = 3'd5,
    JAL  = 3'd6,
    JALR = 3'd7
  } branch_ctl_t;

endpackage

// File: rtl/len5_pkg.sv
// Core-wide architectural parameters shared by every pipeline block.
package len5_pkg;

  localparam int XLEN = 64;

endpackage

// File: rtl/branch_resolver.sv
// Purely combinational branch evaluation: direction, target, link value,
// misprediction and misaligned-target detection for one instruction.
module branch_resolver
  import len5_pkg::*;
  import expipe_pkg::*;
(
  input  branch_ctl_t     branch_type_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] pred_target_i,
  input  logic            pred_taken_i,
  output logic            taken_o,
  output logic [XLEN-1:0] target_o,
  output logic [XLEN-1:0] link_o,
  output logic            mis_o,
  output logic            except_o
);

  logic signed [XLEN-1:0] rs1_s;
  logic signed [XLEN-1:0] rs2_s;
  logic        [XLEN-1:0] jalr_sum;
  logic        [XLEN-1:0] pc_plus4;
  logic                   is_jump;

  assign rs1_s    = rs1_i;
  assign rs2_s    = rs2_i;
  assign jalr_sum = rs1_i + imm_i;
  assign pc_plus4 = pc_i + XLEN'(4);
  assign is_jump  = (branch_type_i == JAL) || (branch_type_i == JALR);

  // Direction from the comparison selected by the branch type
  always_comb begin
    taken_o = 1'b0;
    unique case (branch_type_i)
      BEQ:     taken_o = (rs1_i == rs2_i);
      BNE:     taken_o = (rs1_i != rs2_i);
      BLT:     taken_o = (rs1_s <  rs2_s);
      BGE:     taken_o = (rs1_s >= rs2_s);
      BLTU:    taken_o = (rs1_i <  rs2_i);
      BGEU:    taken_o = (rs1_i >= rs2_i);
      default: taken_o = 1'b1;
    endcase
  end

  // Target, link/next-PC, misprediction and alignment fault
  always_comb begin
    target_o = (branch_type_i == JALR) ? {jalr_sum[XLEN-1:1], 1'b0} : (pc_i + imm_i);
    link_o   = (is_jump || !taken_o) ? pc_plus4 : target_o;
    mis_o    = (taken_o != pred_taken_i) || (taken_o && (target_o != pred_target_i));
`ifdef LEN5_C_EN
    except_o = 1'b0;
`else
    except_o = taken_o && (target_o[1:0] != 2'b00);
`endif
  end

endmodule

// File: rtl/branch_unit.sv
// Branch unit: resolves one branch/jump per cycle, queues results in a small
// in-order buffer toward the ROB and strobes a predictor update one cycle later.
module branch_unit
  import len5_pkg::*;
  import expipe_pkg::*;
#(
  parameter int BUF_DEPTH = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            rs_valid_i,
  output logic            rs_ready_o,
  input  branch_ctl_t     rs_branch_type_i,
  input  rob_idx_t        rs_rob_idx_i,
  input  logic [XLEN-1:0] rs_rs1_i,
  input  logic [XLEN-1:0] rs_rs2_i,
  input  logic [XLEN-1:0] rs_imm_i,
  input  logic [XLEN-1:0] rs_curr_pc_i,
  input  logic [XLEN-1:0] rs_pred_target_i,
  input  logic            rs_pred_taken_i,
  output logic            rs_valid_o,
  input  logic            rs_ready_i,
  output rob_idx_t        rs_rob_idx_o,
  output logic            rs_res_mis_o,
  output logic [XLEN-1:0] rs_link_addr_o,
`ifndef LEN5_C_EN
  output logic            rs_except_raised_o,
`endif
  output logic            bpu_valid_o,
  output logic [XLEN-1:0] bpu_pc_o,
  output logic [XLEN-1:0] bpu_target_o,
  output logic            bpu_taken_o,
  output logic            bpu_res_mis_o
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    rob_idx_t        rob_idx;
    logic            mis;
    logic [XLEN-1:0] link;
    logic            except;
  } entry_t;

  logic            res_taken;
  logic [XLEN-1:0] res_target;
  logic [XLEN-1:0] res_link;
  logic            res_mis;
  logic            res_except;

  entry_t          buf_q [BUF_DEPTH];
  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [CNT_W-1:0] count_q;
  logic            push;
  logic            pop;
  entry_t          head_entry;

  logic            bpu_valid_p1;
  logic [XLEN-1:0] bpu_pc_p1;
  logic [XLEN-1:0] bpu_target_p1;
  logic            bpu_taken_p1;
  logic            bpu_mis_p1;

  branch_resolver u_resolver (
    .branch_type_i (rs_branch_type_i),
    .rs1_i         (rs_rs1_i),
    .rs2_i         (rs_rs2_i),
    .imm_i         (rs_imm_i),
    .pc_i          (rs_curr_pc_i),
    .pred_target_i (rs_pred_target_i),
    .pred_taken_i  (rs_pred_taken_i),
    .taken_o       (res_taken),
    .target_o      (res_target),
    .link_o        (res_link),
    .mis_o         (res_mis),
    .except_o      (res_except)
  );

  // No pass-through: a full buffer refuses even when the head pops this cycle
  assign rs_ready_o = (count_q < CNT_W'(BUF_DEPTH));
  assign rs_valid_o = (count_q != '0);
  assign push       = rs_valid_i && rs_ready_o && !flush_i;
  assign pop        = rs_valid_o && rs_ready_i && !flush_i;
  assign head_entry = buf_q[head_q];

  // ---- stage p0 -> p1: result buffer (in-order FIFO toward the ROB)
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) buf_q[i] <= '0;
    end else if (flush_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        buf_q[tail_q] <= '{rob_idx: rs_rob_idx_i, mis: res_mis, link: res_link, except: res_except};
        tail_q        <= tail_q + PTR_W'(1);
      end
      if (pop) head_q <= head_q + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // ---- stage p0 -> p1: predictor update strobe, one cycle after acceptance
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bpu_valid_p1  <= 1'b0;
      bpu_pc_p1     <= '0;
      bpu_target_p1 <= '0;
      bpu_taken_p1  <= 1'b0;
      bpu_mis_p1    <= 1'b0;
    end else begin
      bpu_valid_p1 <= push;
      if (push) begin
        bpu_pc_p1     <= rs_curr_pc_i;
        bpu_target_p1 <= res_target;
        bpu_taken_p1  <= res_taken;
        bpu_mis_p1    <= res_mis;
      end
    end
  end

  assign rs_rob_idx_o       = head_entry.rob_idx;
  assign rs_res_mis_o       = head_entry.mis;
  assign rs_link_addr_o     = head_entry.link;
`ifndef LEN5_C_EN
  assign rs_except_raised_o = head_entry.except;
`endif
  assign bpu_valid_o        = bpu_valid_p1;
  assign bpu_pc_o           = bpu_pc_p1;
  assign bpu_target_o       = bpu_target_p1;
  assign bpu_taken_o        = bpu_taken_p1;
  assign bpu_res_mis_o      = bpu_mis_p1;

endmodule

// File: tb/tb_branch_unit.sv
// Self-checking bench for branch_unit: directed scenarios followed by
// randomized traffic against a queue-based behavioural model.
module tb_branch_unit;
  import len5_pkg::*;
  import expipe_pkg::*;

  localparam int DEPTH = 2;

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic            flush_i = 1'b0;
  logic            rs_valid_i = 1'b0;
  logic            rs_ready_o;
  branch_ctl_t     rs_branch_type_i = BEQ;
  rob_idx_t        rs_rob_idx_i = '0;
  logic [XLEN-1:0] rs_rs1_i = '0;
  logic [XLEN-1:0] rs_rs2_i = '0;
  logic [XLEN-1:0] rs_imm_i = '0;
  logic [XLEN-1:0] rs_curr_pc_i = '0;
  logic [XLEN-1:0] rs_pred_target_i = '0;
  logic            rs_pred_taken_i = 1'b0;
  logic            rs_valid_o;
  logic            rs_ready_i = 1'b0;
  rob_idx_t        rs_rob_idx_o;
  logic            rs_res_mis_o;
  logic [XLEN-1:0] rs_link_addr_o;
  logic            rs_except_raised_o;
  logic            bpu_valid_o;
  logic [XLEN-1:0] bpu_pc_o;
  logic [XLEN-1:0] bpu_target_o;
  logic            bpu_taken_o;
  logic            bpu_res_mis_o;

  branch_unit #(.BUF_DEPTH(DEPTH)) dut (
    .clk_i              (clk_i),
    .rst_ni             (rst_ni),
    .flush_i            (flush_i),
    .rs_valid_i         (rs_valid_i),
    .rs_ready_o         (rs_ready_o),
    .rs_branch_type_i   (rs_branch_type_i),
    .rs_rob_idx_i       (rs_rob_idx_i),
    .rs_rs1_i           (rs_rs1_i),
    .rs_rs2_i           (rs_rs2_i),
    .rs_imm_i           (rs_imm_i),
    .rs_curr_pc_i       (rs_curr_pc_i),
    .rs_pred_target_i   (rs_pred_target_i),
    .rs_pred_taken_i    (rs_pred_taken_i),
    .rs_valid_o         (rs_valid_o),
    .rs_ready_i         (rs_ready_i),
    .rs_rob_idx_o       (rs_rob_idx_o),
    .rs_res_mis_o       (rs_res_mis_o),
    .rs_link_addr_o     (rs_link_addr_o),
    .rs_except_raised_o (rs_except_raised_o),
    .bpu_valid_o        (bpu_valid_o),
    .bpu_pc_o           (bpu_pc_o),
    .bpu_target_o       (bpu_target_o),
    .bpu_taken_o        (bpu_taken_o),
    .bpu_res_mis_o      (bpu_res_mis_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [63:0] rob;
    logic        taken;
    logic [63:0] target;
    logic [63:0] link;
    logic        mis;
    logic        exc;
    logic [63:0] pc;
  } res_t;

  res_t exp_q[$];
  logic bpu_v_exp;
  res_t bpu_exp;
  int   n_chk  = 0;
  int   n_pass = 0;

  // Resolution rules written straight from the instruction semantics
  function automatic res_t model(branch_ctl_t t, logic [63:0] rob, logic [63:0] a,
                                 logic [63:0] b, logic [63:0] imm, logic [63:0] pc,
                                 logic [63:0] pt, logic ptk);
    res_t r;
    bit   jump;
    jump = (t == JAL) || (t == JALR);
    case (t)
      BEQ:     r.taken = (a == b);
      BNE:     r.taken = (a != b);
      BLT:     r.taken = ($signed(a) < $signed(b));
      BGE:     r.taken = ($signed(a) >= $signed(b));
      BLTU:    r.taken = (a < b);
      BGEU:    r.taken = (a >= b);
      default: r.taken = 1'b1;
    endcase
    r.target = (t == JALR) ? ((a + imm) & ~64'd1) : (pc + imm);
    r.link   = jump ? pc + 64'd4 : (r.taken ? r.target : pc + 64'd4);
    r.mis    = (r.taken != ptk) || (r.taken && (r.target != pt));
    r.exc    = r.taken && ((r.target % 64'd4) != 64'd0);
    r.rob    = rob;
    r.pc     = pc;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic drive(input branch_ctl_t t, input logic [3:0] rob, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] imm, input logic [63:0] pc,
                       input logic [63:0] pt, input logic ptk);
    rs_valid_i       = 1'b1;
    rs_branch_type_i = t;
    rs_rob_idx_i     = rob;
    rs_rs1_i         = a;
    rs_rs2_i         = b;
    rs_imm_i         = imm;
    rs_curr_pc_i     = pc;
    rs_pred_target_i = pt;
    rs_pred_taken_i  = ptk;
  endtask

  // One clock: check ready, advance model on the edge, check outputs at negedge
  task automatic tick();
    bit   acc;
    bit   pop;
    res_t r;
    chk("ready", rs_ready_o, (exp_q.size() < DEPTH));
    acc = rs_valid_i && (exp_q.size() < DEPTH);
    pop = (exp_q.size() != 0) && rs_ready_i;
    r = model(rs_branch_type_i, rs_rob_idx_i, rs_rs1_i, rs_rs2_i, rs_imm_i,
              rs_curr_pc_i, rs_pred_target_i, rs_pred_taken_i);
    @(posedge clk_i);
    if (flush_i) begin
      exp_q.delete();
      bpu_v_exp = 1'b0;
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (acc) begin
        exp_q.push_back(r);
        bpu_exp = r;
      end
      bpu_v_exp = acc;
    end
    @(negedge clk_i);
    chk("valid", rs_valid_o, (exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      chk("rob", rs_rob_idx_o, exp_q[0].rob);
      chk("mis", rs_res_mis_o, exp_q[0].mis);
      chk("link", rs_link_addr_o, exp_q[0].link);
      chk("exc", rs_except_raised_o, exp_q[0].exc);
    end
    chk("bpu_valid", bpu_valid_o, bpu_v_exp);
    if (bpu_v_exp) begin
      chk("bpu_pc", bpu_pc_o, bpu_exp.pc);
      chk("bpu_target", bpu_target_o, bpu_exp.target);
      chk("bpu_taken", bpu_taken_o, bpu_exp.taken);
      chk("bpu_mis", bpu_res_mis_o, bpu_exp.mis);
    end
  endtask

  task automatic drain();
    rs_valid_i = 1'b0;
    flush_i    = 1'b0;
    rs_ready_i = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) tick();
  endtask

  task automatic rand_req(input logic [3:0] rob);
    branch_ctl_t t;
    logic [63:0] a, b, imm, pc, pt;
    logic        ptk;
    res_t        r;
    t   = branch_ctl_t'($urandom_range(0, 7));
    a   = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 7));
    b   = ($urandom_range(0, 2) == 0) ? a : (($urandom_range(0, 1) == 0) ? {$urandom, $urandom}
                                                                       : 64'($urandom_range(0, 7)));
    imm = 64'($signed(12'($urandom)));
    pc  = {32'h0, $urandom} & ~64'd3;
    ptk = $urandom_range(0, 1);
    r   = model(t, rob, a, b, imm, pc, 64'd0, 1'b0);
    pt  = ($urandom_range(0, 1) == 0) ? r.target : {$urandom, $urandom};
    drive(t, rob, a, b, imm, pc, pt, ptk);
  endtask

  initial begin
    bpu_v_exp = 1'b0;
    bpu_exp   = '{default: '0};

    // Reset state
    #12;
    chk("rst_valid", rs_valid_o, 1'b0);
    chk("rst_ready", rs_ready_o, 1'b1);
    chk("rst_bpu_valid", bpu_valid_o, 1'b0);
    chk("rst_link", rs_link_addr_o, 64'd0);
    chk("rst_bpu_target", bpu_target_o, 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // BEQ taken, correctly predicted
    rs_ready_i = 1'b1;
    drive(BEQ, 4'd1, 64'd5, 64'd5, 64'h20, 64'h100, 64'h120, 1'b1);
    tick();
    chk("beq_valid", rs_valid_o, 1'b1);
    chk("beq_mis", rs_res_mis_o, 1'b0);
    chk("beq_link", rs_link_addr_o, 64'h120);
    chk("beq_bpu_taken", bpu_taken_o, 1'b1);

    // BLT signed -1 < 1 taken vs BLTU unsigned not taken
    drive(BLT, 4'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h40, 64'h300, 64'h0, 1'b0);
    tick();
    chk("blt_mis", rs_res_mis_o, 1'b1);
    chk("blt_link", rs_link_addr_o, 64'h340);
    drive(BLTU, 4'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h40, 64'h300, 64'h0, 1'b0);
    tick();
    chk("bltu_taken", bpu_taken_o, 1'b0);
    chk("bltu_mis", rs_res_mis_o, 1'b0);
    chk("bltu_link", rs_link_addr_o, 64'h304);

    // JALR with odd base: bit 0 cleared, bit 1 left set -> misaligned
    drive(JALR, 4'd4, 64'h1003, 64'd0, 64'd0, 64'h200, 64'h1002, 1'b1);
    tick();
    chk("jalr_bpu_target", bpu_target_o, 64'h1002);
    chk("jalr_link", rs_link_addr_o, 64'h204);
    chk("jalr_exc", rs_except_raised_o, 1'b1);
    drain();

    // Backpressure: three back-to-back with consumer stalled
    rs_ready_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      rand_req(4'(5 + k));
      tick();
    end
    rand_req(4'd7);
    chk("bp_ready_low", rs_ready_o, 1'b0);
    tick();
    rs_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (rs_ready_o) begin
        tick();
        rs_valid_i = 1'b0;
        break;
      end
      tick();
    end
    chk("bp_third_taken", rs_valid_i, 1'b0);
    drain();

    // Full buffer: pop and push together -> push refused, one left
    rs_ready_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      rand_req(4'(8 + k));
      tick();
    end
    rs_ready_i = 1'b1;
    rand_req(4'd10);
    tick();
    chk("full_pop_valid", rs_valid_o, 1'b1);
    chk("full_pop_ready", rs_ready_o, 1'b1);
    chk("full_pop_no_bpu", bpu_valid_o, 1'b0);
    chk("full_pop_rob", rs_rob_idx_o, 64'd9);
    drain();

    // Flush with one buffered plus one accepting, then with two buffered
    rs_ready_i = 1'b0;
    rand_req(4'd11);
    tick();
    rand_req(4'd12);
    flush_i = 1'b1;
    tick();
    chk("flush1_valid", rs_valid_o, 1'b0);
    chk("flush1_bpu", bpu_valid_o, 1'b0);
    flush_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      rand_req(4'(13 + k));
      tick();
    end
    rand_req(4'd15);
    flush_i = 1'b1;
    tick();
    chk("flush2_valid", rs_valid_o, 1'b0);
    chk("flush2_ready", rs_ready_o, 1'b1);
    drain();

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 9) < 7) rand_req(4'($urandom));
      else rs_valid_i = 1'b0;
      rs_ready_i = ($urandom_range(0, 9) < 6);
      flush_i    = ($urandom_range(0, 99) < 3);
      tick();
    end

    // Asynchronous reset mid-operation
    rs_valid_i = 1'b0;
    flush_i    = 1'b0;
    rs_ready_i = 1'b0;
    drain();
    rs_ready_i = 1'b0;
    drive(JAL, 4'd3, 64'd0, 64'd0, 64'h8, 64'h400, 64'h0, 1'b0);
    tick();
    rs_valid_i = 1'b0;
    #2;
    rst_ni = 1'b0;
    #1;
    chk("arst_valid", rs_valid_o, 1'b0);
    chk("arst_ready", rs_ready_o, 1'b1);
    chk("arst_bpu_valid", bpu_valid_o, 1'b0);
    chk("arst_link", rs_link_addr_o, 64'd0);
    exp_q.delete();
    bpu_v_exp = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    rs_ready_i = 1'b1;
    drive(BNE, 4'd2, 64'd1, 64'd2, 64'h10, 64'h500, 64'h510, 1'b1);
    tick();
    rs_valid_i = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
